// File: rtl/cond_exec_controller.sv
// Conditional-execution controller: ARM condition evaluation against the
// status register, one-cycle flag hazard stall, and post-branch flush window.
module cond_exec_controller #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       id_branch,
  input  logic [3:0] alu_flags,
  output logic       issue,
  output logic       exec_en,
  output logic       hazard_stall,
  output logic       branch_taken,
  output logic       flush,
  output logic [3:0] status
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] COND_AL = 4'b1110;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_pending;
  logic [3:0] r_status;
  logic       w_cond_pass;
  logic       w_z, w_c, w_n, w_v;

  assign {w_z, w_c, w_n, w_v} = r_status;
  assign status = r_status;
  assign flush  = (r_state == FLUSH) && !rst;

  always_comb begin
    w_cond_pass = 1'b0;
    case (id_cond)
      4'b0000: w_cond_pass = w_z;
      4'b0001: w_cond_pass = !w_z;
      4'b0010: w_cond_pass = w_c;
      4'b0011: w_cond_pass = !w_c;
      4'b0100: w_cond_pass = w_n;
      4'b0101: w_cond_pass = !w_n;
      4'b0110: w_cond_pass = w_v;
      4'b0111: w_cond_pass = !w_v;
      4'b1000: w_cond_pass = w_c && !w_z;
      4'b1001: w_cond_pass = !w_c || w_z;
      4'b1010: w_cond_pass = (w_n == w_v);
      4'b1011: w_cond_pass = (w_n != w_v);
      4'b1100: w_cond_pass = !w_z && (w_n == w_v);
      4'b1101: w_cond_pass = w_z || (w_n != w_v);
      4'b1110: w_cond_pass = 1'b1;
      default: w_cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    issue        = 1'b0;
    exec_en      = 1'b0;
    hazard_stall = 1'b0;
    branch_taken = 1'b0;
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    if (!rst && !freeze) begin
      case (r_state)
        RUN: begin
          if (id_valid) begin
            // AL never depends on flags, so it may bypass the pending update
            if (r_pending && id_cond != COND_AL) begin
              hazard_stall = 1'b1;
            end else begin
              issue        = 1'b1;
              exec_en      = w_cond_pass;
              branch_taken = w_cond_pass && id_branch;
              if (w_cond_pass && id_branch) begin
                w_state_nxt = FLUSH;
                w_cnt_nxt   = 3'(FLUSH_CYCLES);
              end
            end
          end
        end
        FLUSH: begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_status  <= '0;
    end else if (!freeze) begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= exec_en && id_s;
      if (r_pending) r_status <= alu_flags;
    end
  end

endmodule

// File: tb/tb_cond_exec_controller.sv
// Bench for cond_exec_controller: a flag/flush-window model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_cond_exec_controller;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       freeze = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] id_cond = '0;
  logic       id_s = 1'b0;
  logic       id_branch = 1'b0;
  logic [3:0] alu_flags = '0;
  logic       issue, exec_en, hazard_stall, branch_taken, flush;
  logic [3:0] status;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [3:0] m_status = '0;
  bit         m_pend   = 1'b0;
  int         m_left   = 0;
  logic [4:0] e_cmp, e_upd;
  logic [3:0] sweep_st [4] = '{4'h0, 4'h9, 4'h6, 4'hF};

  cond_exec_controller #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid),
    .id_cond(id_cond), .id_s(id_s), .id_branch(id_branch),
    .alu_flags(alu_flags), .issue(issue), .exec_en(exec_en),
    .hazard_stall(hazard_stall), .branch_taken(branch_taken),
    .flush(flush), .status(status)
  );

  always #5 clk = ~clk;

  // Conditions come in complementary pairs; bit 0 inverts the base test.
  function automatic bit cond_ok(logic [3:0] c, logic [3:0] s);
    bit z, cc, n, v, base;
    z = s[3]; cc = s[2]; n = s[1]; v = s[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  // {issue, exec_en, hazard_stall, branch_taken, flush}
  function automatic logic [4:0] model_out();
    logic [4:0] r;
    r = '0;
    if (rst) return r;
    r[0] = (m_left > 0);
    if (freeze || m_left > 0 || !id_valid) return r;
    if (m_pend && id_cond != 4'hE) r[2] = 1'b1;
    else begin
      r[4] = 1'b1;
      r[3] = cond_ok(id_cond, m_status);
      r[1] = r[3] && id_branch;
    end
    return r;
  endfunction

  task automatic chk(string name, logic [3:0] got, logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    e_upd = model_out();
    if (rst) begin
      m_status = '0; m_pend = 1'b0; m_left = 0;
    end else if (!freeze) begin
      if (m_pend) m_status = alu_flags;
      m_pend = e_upd[3] && id_s;
      if (m_left > 0) m_left--;
      else if (e_upd[1]) m_left = FC;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      e_cmp = model_out();
      chk("m_issue",  {3'b0, issue},        {3'b0, e_cmp[4]});
      chk("m_exec",   {3'b0, exec_en},      {3'b0, e_cmp[3]});
      chk("m_stall",  {3'b0, hazard_stall}, {3'b0, e_cmp[2]});
      chk("m_branch", {3'b0, branch_taken}, {3'b0, e_cmp[1]});
      chk("m_flush",  {3'b0, flush},        {3'b0, e_cmp[0]});
      chk("m_status", status, m_status);
    end
  end

  task automatic step(bit v, logic [3:0] c, bit s, bit b, logic [3:0] a, bit f, bit r);
    @(posedge clk); #1;
    id_valid = v; id_cond = c; id_s = s; id_branch = b;
    alu_flags = a; freeze = f; rst = r;
    @(negedge clk);
  endtask

  function automatic logic [3:0] b4(logic x);
    return {3'b0, x};
  endfunction

  initial begin
    step(0, 4'h0, 0, 0, 4'h0, 0, 1);
    step(0, 4'h0, 0, 0, 4'h0, 1, 1);
    chk_en = 1'b1;
    chk("rst_status", status, 4'h0);
    chk("rst_flush", b4(flush), 4'h0);
    chk("rst_issue", b4(issue), 4'h0);

    step(1, 4'h0, 0, 0, 4'h0, 0, 0);
    chk("eq_issue", b4(issue), 4'h1);
    chk("eq_exec", b4(exec_en), 4'h0);
    step(1, 4'h1, 0, 0, 4'h0, 0, 0);
    chk("ne_exec", b4(exec_en), 4'h1);

    step(1, 4'hE, 1, 0, 4'h0, 0, 0);
    chk("al_s_exec", b4(exec_en), 4'h1);
    step(1, 4'h0, 0, 0, 4'h8, 0, 0);
    chk("haz_stall", b4(hazard_stall), 4'h1);
    chk("haz_issue", b4(issue), 4'h0);
    step(1, 4'h0, 0, 0, 4'h0, 0, 0);
    chk("haz_status", status, 4'h8);
    chk("haz_stall_gone", b4(hazard_stall), 4'h0);
    chk("haz_exec", b4(exec_en), 4'h1);

    step(1, 4'hE, 0, 1, 4'h0, 0, 0);
    chk("br_taken", b4(branch_taken), 4'h1);
    step(1, 4'hE, 0, 1, 4'h0, 0, 0);
    chk("br_flush1", b4(flush), 4'h1);
    chk("br_flush1_issue", b4(issue), 4'h0);
    step(1, 4'hE, 0, 1, 4'h0, 0, 0);
    chk("br_flush2", b4(flush), 4'h1);
    step(1, 4'hE, 0, 0, 4'h0, 0, 0);
    chk("br_done_flush", b4(flush), 4'h0);
    chk("br_resume", b4(issue), 4'h1);

    step(1, 4'hE, 1, 0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 0, 4'h3, 0, 0);
    step(1, 4'hA, 0, 0, 4'h0, 0, 0);
    chk("nv_status", status, 4'h3);
    chk("ge", b4(exec_en), 4'h1);
    step(1, 4'hB, 0, 0, 4'h0, 0, 0);
    chk("lt", b4(exec_en), 4'h0);
    step(1, 4'hD, 0, 0, 4'h0, 0, 0);
    chk("le", b4(exec_en), 4'h0);
    step(1, 4'hC, 0, 0, 4'h0, 0, 0);
    chk("gt", b4(exec_en), 4'h1);

    step(1, 4'hE, 1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'h0, 0, 0, 4'h5, 1, 0);
      chk("frz_status", status, 4'h3);
      chk("frz_issue", b4(issue), 4'h0);
      chk("frz_stall", b4(hazard_stall), 4'h0);
    end
    step(0, 4'h0, 0, 0, 4'h5, 0, 0);
    chk("frz_hold_status", status, 4'h3);
    step(0, 4'h0, 0, 0, 4'h0, 0, 0);
    chk("frz_upd_status", status, 4'h5);

    step(1, 4'h0, 1, 1, 4'h0, 0, 0);
    chk("fail_br_issue", b4(issue), 4'h1);
    chk("fail_br_taken", b4(branch_taken), 4'h0);
    step(1, 4'h0, 0, 0, 4'hF, 0, 0);
    chk("fail_no_pend", status, 4'h5);
    chk("fail_no_stall", b4(hazard_stall), 4'h0);
    chk("fail_no_flush", b4(flush), 4'h0);

    step(1, 4'hE, 0, 1, 4'h0, 0, 0);
    step(1, 4'hE, 0, 0, 4'h0, 1, 0);
    step(1, 4'hE, 0, 0, 4'h0, 1, 0);
    chk("frz_flush_hold", b4(flush), 4'h1);
    step(0, 4'h0, 0, 0, 4'h0, 0, 0);
    step(0, 4'h0, 0, 0, 4'h0, 0, 0);
    chk("frz_flush_last", b4(flush), 4'h1);
    step(1, 4'hE, 0, 0, 4'h0, 0, 0);
    chk("frz_flush_end", b4(flush), 4'h0);

    step(1, 4'hE, 1, 1, 4'h0, 0, 0);
    step(0, 4'h0, 0, 0, 4'h6, 0, 0);
    step(0, 4'h0, 0, 0, 4'h0, 0, 0);
    chk("flush_status_upd", status, 4'h6);
    chk("flush_status_fl", b4(flush), 4'h1);
    step(0, 4'h0, 0, 0, 4'h0, 0, 0);

    step(1, 4'hE, 1, 1, 4'h0, 0, 0);
    step(1, 4'hE, 0, 0, 4'h9, 1, 1);
    chk("rstfl_flush", b4(flush), 4'h0);
    step(1, 4'hE, 0, 0, 4'h0, 0, 0);
    chk("rstfl_after_flush", b4(flush), 4'h0);
    chk("rstfl_status", status, 4'h0);
    chk("rstfl_issue", b4(issue), 4'h1);

    foreach (sweep_st[k]) begin
      step(1, 4'hE, 1, 0, 4'h0, 0, 0);
      step(0, 4'h0, 0, 0, sweep_st[k], 0, 0);
      for (int c = 0; c < 16; c++) step(1, 4'(c), 0, 0, 4'h0, 0, 0);
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
